// File: rtl/commit_halt_ctrl.sv
// Retirement sequencer between RV64 writeback and the difftest layer: gates retirement
// (run / N-step / halted), registers one commit record per retire and latches the halt cause.
module commit_halt_ctrl #(
  parameter int CNT_W     = 64,
  parameter int STEP_W    = 16,
  parameter int WDOG      = 1024,
  parameter int START_RUN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_valid,
  output logic              o_wb_ready,
  input  logic [63:0]       i_wb_pc,
  input  logic [31:0]       i_wb_inst,
  input  logic              i_wb_is_break,
  input  logic [63:0]       i_a0,
  input  logic              i_host_cmd_valid,
  input  logic [1:0]        i_host_cmd,
  input  logic [STEP_W-1:0] i_host_step_n,
  output logic              o_host_cmd_ready,
  output logic              o_cm_valid,
  output logic [63:0]       o_cm_pc,
  output logic [31:0]       o_cm_inst,
  output logic [CNT_W-1:0]  o_retired_cnt,
  output logic              o_halted,
  output logic [1:0]        o_halt_reason,
  output logic [63:0]       o_exit_code,
  output logic              o_good_trap
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_STEP = 2'd1, S_HALTED = 2'd2} state_e;
  typedef enum logic [1:0] {R_NONE = 2'd0, R_EBREAK = 2'd1, R_HOST = 2'd2, R_WDOG = 2'd3} reason_e;
  typedef enum logic [1:0] {CMD_RUN = 2'd0, CMD_STEP = 2'd1, CMD_HALT = 2'd2, CMD_RSVD = 2'd3} cmd_e;

  localparam state_e          RESET_STATE = (START_RUN != 0) ? S_RUN : S_HALTED;
  localparam int              WD_W        = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam int              WD_LAST_I   = (WDOG > 0) ? WDOG - 1 : 0;
  localparam logic [WD_W-1:0] WD_LAST     = WD_W'(WD_LAST_I);

  state_e              r_state;
  reason_e             r_halt_reason;
  logic [STEP_W-1:0]   r_step_left;
  logic [WD_W-1:0]     r_wdog_cnt;
  logic                r_cm_valid;
  logic [63:0]         r_cm_pc;
  logic [31:0]         r_cm_inst;
  logic [CNT_W-1:0]    r_retired_cnt;
  logic [63:0]         r_exit_code;
  logic                r_good_trap;

  state_e              w_state_nxt;
  reason_e             w_reason_nxt;
  logic [STEP_W-1:0]   w_step_left_nxt;
  logic [WD_W-1:0]     w_wdog_nxt;
  logic [STEP_W-1:0]   w_step_load;
  cmd_e                w_cmd;
  logic                w_retire;
  logic                w_accept;
  logic                w_terminal;
  logic                w_wdog_fire;
  logic                w_step_last;

  assign w_cmd       = cmd_e'(i_host_cmd);
  assign w_step_load = (i_host_step_n == '0) ? STEP_W'(1) : i_host_step_n;
  assign w_terminal  = (r_halt_reason == R_EBREAK) || (r_halt_reason == R_WDOG);
  assign w_retire    = i_wb_valid & o_wb_ready;
  assign w_accept    = i_host_cmd_valid & o_host_cmd_ready;
  assign w_step_last = (r_state == S_STEP) && (r_step_left == STEP_W'(1));
  assign w_wdog_fire = (WDOG != 0) && (r_state != S_HALTED) && !w_retire && (r_wdog_cnt == WD_LAST);

  assign o_wb_ready       = (r_state == S_RUN) || ((r_state == S_STEP) && (r_step_left != '0));
  assign o_host_cmd_ready = !w_terminal;
  assign o_halted         = (r_state == S_HALTED);
  assign o_halt_reason    = r_halt_reason;
  assign o_cm_valid       = r_cm_valid;
  assign o_cm_pc          = r_cm_pc;
  assign o_cm_inst        = r_cm_inst;
  assign o_retired_cnt    = r_retired_cnt;
  assign o_exit_code      = r_exit_code;
  assign o_good_trap      = r_good_trap;

  // Halt sources in priority order: ebreak, watchdog, host command, step completion.
  always_comb begin
    w_state_nxt     = r_state;
    w_reason_nxt    = r_halt_reason;
    w_step_left_nxt = r_step_left;
    if (w_retire && (r_state == S_STEP)) begin
      w_step_left_nxt = r_step_left - STEP_W'(1);
    end
    if (w_retire && i_wb_is_break) begin
      w_state_nxt  = S_HALTED;
      w_reason_nxt = R_EBREAK;
    end else if (w_wdog_fire) begin
      w_state_nxt  = S_HALTED;
      w_reason_nxt = R_WDOG;
    end else if (w_accept && (w_cmd != CMD_RSVD)) begin
      case (w_cmd)
        CMD_RUN: begin
          w_state_nxt  = S_RUN;
          w_reason_nxt = R_NONE;
        end
        CMD_STEP: begin
          w_state_nxt     = S_STEP;
          w_reason_nxt    = R_NONE;
          w_step_left_nxt = w_step_load;
        end
        default: begin
          w_state_nxt  = S_HALTED;
          w_reason_nxt = R_HOST;
        end
      endcase
    end else if (w_retire && w_step_last) begin
      w_state_nxt  = S_HALTED;
      w_reason_nxt = R_HOST;
    end
  end

  // The idle counter only runs across consecutive retire-free cycles in one running state.
  always_comb begin
    w_wdog_nxt = r_wdog_cnt + WD_W'(1);
    if ((WDOG == 0) || w_retire || (w_state_nxt != r_state) || (r_state == S_HALTED)) begin
      w_wdog_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RESET_STATE;
      r_halt_reason <= R_NONE;
      r_step_left   <= '0;
      r_wdog_cnt    <= '0;
      r_cm_valid    <= 1'b0;
      r_cm_pc       <= '0;
      r_cm_inst     <= '0;
      r_retired_cnt <= '0;
      r_exit_code   <= '0;
      r_good_trap   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_halt_reason <= w_reason_nxt;
      r_step_left   <= w_step_left_nxt;
      r_wdog_cnt    <= w_wdog_nxt;
      r_cm_valid    <= w_retire;
      if (w_retire) begin
        r_cm_pc       <= i_wb_pc;
        r_cm_inst     <= i_wb_inst;
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
      if (w_retire && i_wb_is_break) begin
        r_exit_code <= i_a0;
        r_good_trap <= (i_a0 == '0);
      end
    end
  end

endmodule

// File: tb/tb_commit_halt_ctrl.sv
// Scoreboard bench for commit_halt_ctrl: two instances (start-in-run with a 16-cycle watchdog,
// start-halted with no watchdog) share one randomized stimulus stream and one reference model.
module tb_commit_halt_ctrl;

  localparam int ST_RUN  = 0;
  localparam int ST_STEP = 1;
  localparam int ST_HALT = 2;

  typedef struct {
    int          st;
    int          stepLeft;
    int          idle;
    int          reason;
    logic [63:0] exitCode;
    bit          good;
    logic [63:0] cnt;
  } model_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] cnt;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbValid;
  logic [63:0] wbPc;
  logic [31:0] wbInst;
  logic        wbIsBreak;
  logic [63:0] a0;
  logic        cmdValid;
  logic [1:0]  cmd;
  logic [15:0] stepN;

  logic        wbReady  [2];
  logic        cmdReady [2];
  logic        cmValid  [2];
  logic [63:0] cmPc     [2];
  logic [31:0] cmInst   [2];
  logic [63:0] retCnt   [2];
  logic        halted   [2];
  logic [1:0]  reason   [2];
  logic [63:0] exitCode [2];
  logic        goodTrap [2];

  model_t mdl [2];
  rec_t   q0[$];
  rec_t   q1[$];
  int     nCompare = 0;
  int     nMiss    = 0;

  always #5 clk = ~clk;

  commit_halt_ctrl #(.CNT_W(64), .STEP_W(16), .WDOG(16), .START_RUN(1)) u_run (
    .clk(clk), .rst(rst), .i_wb_valid(wbValid), .o_wb_ready(wbReady[0]),
    .i_wb_pc(wbPc), .i_wb_inst(wbInst), .i_wb_is_break(wbIsBreak), .i_a0(a0),
    .i_host_cmd_valid(cmdValid), .i_host_cmd(cmd), .i_host_step_n(stepN),
    .o_host_cmd_ready(cmdReady[0]), .o_cm_valid(cmValid[0]), .o_cm_pc(cmPc[0]),
    .o_cm_inst(cmInst[0]), .o_retired_cnt(retCnt[0]), .o_halted(halted[0]),
    .o_halt_reason(reason[0]), .o_exit_code(exitCode[0]), .o_good_trap(goodTrap[0])
  );

  commit_halt_ctrl #(.CNT_W(64), .STEP_W(16), .WDOG(0), .START_RUN(0)) u_halt (
    .clk(clk), .rst(rst), .i_wb_valid(wbValid), .o_wb_ready(wbReady[1]),
    .i_wb_pc(wbPc), .i_wb_inst(wbInst), .i_wb_is_break(wbIsBreak), .i_a0(a0),
    .i_host_cmd_valid(cmdValid), .i_host_cmd(cmd), .i_host_step_n(stepN),
    .o_host_cmd_ready(cmdReady[1]), .o_cm_valid(cmValid[1]), .o_cm_pc(cmPc[1]),
    .o_cm_inst(cmInst[1]), .o_retired_cnt(retCnt[1]), .o_halted(halted[1]),
    .o_halt_reason(reason[1]), .o_exit_code(exitCode[1]), .o_good_trap(goodTrap[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompare++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wdogOf(input int i);
    return (i == 0) ? 16 : 0;
  endfunction

  function automatic model_t modelReset(input int i);
    model_t m;
    m.st       = (i == 0) ? ST_RUN : ST_HALT;
    m.stepLeft = 0;
    m.idle     = 0;
    m.reason   = 0;
    m.exitCode = '0;
    m.good     = 1'b0;
    m.cnt      = '0;
    return m;
  endfunction

  function automatic bit modelReady(input model_t m);
    return (m.st == ST_RUN) || (m.st == ST_STEP && m.stepLeft > 0);
  endfunction

  function automatic bit modelCmdReady(input model_t m);
    return !(m.reason == 1 || m.reason == 3);
  endfunction

  // Reference behaviour: retirement bookkeeping, then the highest-priority halt/command event.
  function automatic model_t modelNext(input model_t m, input int wdog, input bit retire,
                                       input bit brk, input logic [63:0] a0v, input bit accept,
                                       input logic [1:0] c, input int n);
    model_t nx;
    nx = m;
    if (retire) begin
      nx.cnt = m.cnt + 64'd1;
      if (m.st == ST_STEP) nx.stepLeft = m.stepLeft - 1;
    end
    if (retire && brk) begin
      nx.st       = ST_HALT;
      nx.reason   = 1;
      nx.exitCode = a0v;
      nx.good     = (a0v == 64'd0);
    end else if (wdog != 0 && m.st != ST_HALT && !retire && m.idle == wdog - 1) begin
      nx.st     = ST_HALT;
      nx.reason = 3;
    end else if (accept && c != 2'd3) begin
      if (c == 2'd0) begin
        nx.st     = ST_RUN;
        nx.reason = 0;
      end else if (c == 2'd1) begin
        nx.st       = ST_STEP;
        nx.reason   = 0;
        nx.stepLeft = (n == 0) ? 1 : n;
      end else begin
        nx.st     = ST_HALT;
        nx.reason = 2;
      end
    end else if (retire && m.st == ST_STEP && nx.stepLeft == 0) begin
      nx.st     = ST_HALT;
      nx.reason = 2;
    end
    nx.idle = (retire || nx.st != m.st || m.st == ST_HALT) ? 0 : m.idle + 1;
    return nx;
  endfunction

  // One clock of stimulus: check combinational outputs, predict, push commits, check registers.
  task automatic applyStimulus(input bit r, input bit v, input logic [63:0] pc,
                               input logic [31:0] inst, input bit brk, input logic [63:0] a0v,
                               input bit cv, input logic [1:0] c, input logic [15:0] n);
    model_t nxt [2];
    bit     retire;
    bit     accept;
    rec_t   rec;
    @(negedge clk);
    rst = r; wbValid = v; wbPc = pc; wbInst = inst; wbIsBreak = brk;
    a0 = a0v; cmdValid = cv; cmd = c; stepN = n;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("wb_ready[%0d]", i), 64'(wbReady[i]), 64'(modelReady(mdl[i])));
      checkOutput($sformatf("host_cmd_ready[%0d]", i), 64'(cmdReady[i]), 64'(modelCmdReady(mdl[i])));
      retire = v && modelReady(mdl[i]);
      accept = cv && modelCmdReady(mdl[i]);
      if (r) begin
        nxt[i] = modelReset(i);
      end else begin
        nxt[i] = modelNext(mdl[i], wdogOf(i), retire, brk, a0v, accept, c, int'(n));
        if (retire) begin
          rec.pc = pc; rec.inst = inst; rec.cnt = nxt[i].cnt;
          if (i == 0) q0.push_back(rec);
          else q1.push_back(rec);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mdl[i] = nxt[i];
      checkOutput($sformatf("halted[%0d]", i), 64'(halted[i]), 64'(mdl[i].st == ST_HALT));
      checkOutput($sformatf("halt_reason[%0d]", i), 64'(reason[i]), 64'(mdl[i].reason));
      checkOutput($sformatf("exit_code[%0d]", i), exitCode[i], mdl[i].exitCode);
      checkOutput($sformatf("good_trap[%0d]", i), 64'(goodTrap[i]), 64'(mdl[i].good));
      checkOutput($sformatf("retired_cnt[%0d]", i), retCnt[i], mdl[i].cnt);
    end
  endtask

  task automatic idleCycles(input int k);
    for (int j = 0; j < k; j++) applyStimulus(0, 0, '0, '0, 0, '0, 0, 2'd0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, '0, '0, 0, '0, 0, 2'd0, '0);
    applyStimulus(1, 0, '0, '0, 0, '0, 0, 2'd0, '0);
  endtask

  // Monitors: every cm_valid pulse must match the oldest predicted commit, and none may be late.
  always @(negedge clk) begin
    rec_t r;
    if (cmValid[0] === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("cm_unexpected[0]", 64'(cmValid[0]), 64'd0);
      end else begin
        r = q0.pop_front();
        checkOutput("cm_pc[0]", cmPc[0], r.pc);
        checkOutput("cm_inst[0]", 64'(cmInst[0]), 64'(r.inst));
        checkOutput("cm_cnt[0]", retCnt[0], r.cnt);
      end
    end else if (q0.size() != 0) begin
      checkOutput("cm_missing[0]", 64'(cmValid[0]), 64'd1);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    rec_t r;
    if (cmValid[1] === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("cm_unexpected[1]", 64'(cmValid[1]), 64'd0);
      end else begin
        r = q1.pop_front();
        checkOutput("cm_pc[1]", cmPc[1], r.pc);
        checkOutput("cm_inst[1]", 64'(cmInst[1]), 64'(r.inst));
        checkOutput("cm_cnt[1]", retCnt[1], r.cnt);
      end
    end else if (q1.size() != 0) begin
      checkOutput("cm_missing[1]", 64'(cmValid[1]), 64'd1);
      void'(q1.pop_front());
    end
  end

  initial begin
    int  stuck;
    bit  busy;
    bit  rv;
    bit  v;
    bit  brk;
    bit  cv;
    logic [63:0] a0v;
    rst = 1'b1; wbValid = 1'b0; wbPc = '0; wbInst = '0; wbIsBreak = 1'b0;
    a0 = '0; cmdValid = 1'b0; cmd = 2'd0; stepN = '0;
    repeat (2) @(posedge clk);
    #1;
    mdl[0] = modelReset(0);
    mdl[1] = modelReset(1);
    $display("[TB] directed sequences");

    doReset();
    checkOutput("reset_halted_run", 64'(halted[0]), 64'd0);
    checkOutput("reset_halted_halt", 64'(halted[1]), 64'd1);
    applyStimulus(0, 1, 64'h8000_0000, 32'h0000_0013, 0, '0, 0, 2'd0, '0);
    applyStimulus(0, 1, 64'h8000_0004, 32'h0010_0093, 0, '0, 0, 2'd0, '0);
    applyStimulus(0, 1, 64'h8000_0008, 32'h0020_0113, 0, '0, 0, 2'd0, '0);
    idleCycles(2);
    checkOutput("t1_retired_cnt", retCnt[0], 64'd3);

    applyStimulus(0, 1, 64'h8000_000c, 32'h0010_0073, 1, 64'd0, 0, 2'd0, '0);
    idleCycles(1);
    checkOutput("t2_reason", 64'(reason[0]), 64'd1);
    checkOutput("t2_good_trap", 64'(goodTrap[0]), 64'd1);
    checkOutput("t2_wb_ready", 64'(wbReady[0]), 64'd0);
    checkOutput("t2_cmd_ready", 64'(cmdReady[0]), 64'd0);
    doReset();
    applyStimulus(0, 1, 64'h8000_0010, 32'h0010_0073, 1, 64'd5, 0, 2'd0, '0);
    idleCycles(1);
    checkOutput("t2_exit_code", exitCode[0], 64'd5);
    checkOutput("t2_bad_trap", 64'(goodTrap[0]), 64'd0);

    doReset();
    applyStimulus(0, 0, '0, '0, 0, '0, 1, 2'd2, '0);
    applyStimulus(0, 1, 64'h8000_0100, 32'h13, 0, '0, 1, 2'd1, 16'd2);
    for (int j = 0; j < 4; j++) applyStimulus(0, 1, 64'h8000_0104 + 64'(4 * j), 32'h13, 0, '0, 0, 2'd0, '0);
    checkOutput("t3_step2_cnt", retCnt[0], 64'd2);
    checkOutput("t3_step2_reason", 64'(reason[0]), 64'd2);
    applyStimulus(0, 1, 64'h8000_0200, 32'h13, 0, '0, 1, 2'd1, 16'd0);
    for (int j = 0; j < 3; j++) applyStimulus(0, 1, 64'h8000_0204 + 64'(4 * j), 32'h13, 0, '0, 0, 2'd0, '0);
    checkOutput("t3_step0_cnt", retCnt[0], 64'd3);

    doReset();
    idleCycles(15);
    checkOutput("t4_no_halt_at_15", 64'(halted[0]), 64'd0);
    idleCycles(1);
    checkOutput("t4_wdog_reason", 64'(reason[0]), 64'd3);
    doReset();
    idleCycles(14);
    applyStimulus(0, 1, 64'h8000_0300, 32'h13, 0, '0, 0, 2'd0, '0);
    idleCycles(10);
    checkOutput("t4_wdog_cleared", 64'(halted[0]), 64'd0);

    doReset();
    applyStimulus(0, 1, 64'h8000_0400, 32'h13, 0, '0, 1, 2'd2, '0);
    checkOutput("t5_halt_retire_cnt", retCnt[0], 64'd1);
    checkOutput("t5_halt_reason", 64'(reason[0]), 64'd2);
    doReset();
    applyStimulus(0, 1, 64'h8000_0404, 32'h0010_0073, 1, 64'd7, 1, 2'd0, '0);
    checkOutput("t5_ebreak_beats_run", 64'(reason[0]), 64'd1);

    doReset();
    applyStimulus(0, 0, '0, '0, 0, '0, 1, 2'd1, 16'd5);
    applyStimulus(1, 1, 64'h8000_0500, 32'h13, 0, '0, 0, 2'd0, '0);
    checkOutput("t6_reset_cnt", retCnt[0], 64'd0);
    checkOutput("t6_reset_cm_valid", 64'(cmValid[0]), 64'd0);
    applyStimulus(0, 1, 64'h8000_0504, 32'h13, 0, '0, 0, 2'd0, '0);
    checkOutput("t6_halted_no_retire", retCnt[1], 64'd0);

    $display("[TB] randomized sequences");
    stuck = 0;
    busy  = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) busy = ($urandom_range(0, 2) != 0);
      stuck = (mdl[0].st == ST_HALT) ? stuck + 1 : 0;
      rv  = ($urandom_range(0, 199) == 0) || (stuck > 12);
      v   = busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      brk = ($urandom_range(0, 59) == 0);
      cv  = ($urandom_range(0, 5) == 0);
      a0v = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      applyStimulus(rv, v, {$urandom, $urandom}, $urandom, brk, a0v, cv,
                    2'($urandom_range(0, 3)), 16'($urandom_range(0, 4)));
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drain[0]", 64'(q0.size()), 64'd0);
    checkOutput("scoreboard_drain[1]", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nCompare, nMiss);
    $finish;
  end

endmodule
